// File: rtl/guess_entry_writer.sv
`default_nettype none
// ============================================================================
//  Module   : guess_entry_writer
//  Purpose  : Writer side of the 8-slot letter display path. Captures player
//             letter entry into eight 5-bit slots, then grades a submitted
//             guess against a latched copy of the target word, one slot per
//             clock.
//  Ports    : clk, rst_n (sync, active-low)
//             letter_in/letter_valid, backspace, submit, clear : input strobes
//             target_word[39:0] : slot i = target_word[5i+4:5i]
//             alphabet_0..7     : slot contents
//             is_correct_0..7   : per-slot grade flags
//             mode (0 entry / 1 graded), cursor, full, busy,
//             all_correct, attempts (saturating graded-guess count)
//  Revision : 1.0 - initial release
// ============================================================================
module guess_entry_writer #(
    parameter int         SLOTS      = 8,
    parameter logic [4:0] BLANK_CODE = 5'd27,
    parameter logic [4:0] CHAR_MAX   = 5'd25
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  letter_in,
    input  logic        letter_valid,
    input  logic        backspace,
    input  logic        submit,
    input  logic        clear,
    input  logic [39:0] target_word,
    output logic [4:0]  alphabet_0,
    output logic [4:0]  alphabet_1,
    output logic [4:0]  alphabet_2,
    output logic [4:0]  alphabet_3,
    output logic [4:0]  alphabet_4,
    output logic [4:0]  alphabet_5,
    output logic [4:0]  alphabet_6,
    output logic [4:0]  alphabet_7,
    output logic        is_correct_0,
    output logic        is_correct_1,
    output logic        is_correct_2,
    output logic        is_correct_3,
    output logic        is_correct_4,
    output logic        is_correct_5,
    output logic        is_correct_6,
    output logic        is_correct_7,
    output logic        mode,
    output logic [3:0]  cursor,
    output logic        full,
    output logic        busy,
    output logic        all_correct,
    output logic [3:0]  attempts
);

    localparam logic [1:0] c_ST_EDIT  = 2'd0;
    localparam logic [1:0] c_ST_CHECK = 2'd1;
    localparam logic [1:0] c_ST_SHOW  = 2'd2;
    localparam logic [3:0] c_SLOTS4   = 4'(SLOTS);
    localparam logic [2:0] c_LAST_IDX = 3'(SLOTS - 1);

    logic [1:0]       r_state;
    logic [4:0]       r_slot   [0:SLOTS-1];
    logic [4:0]       r_shadow [0:SLOTS-1];
    logic [SLOTS-1:0] r_flag;
    logic [3:0]       r_cursor;
    logic [2:0]       r_idx;
    logic             r_mode;
    logic             r_busy;
    logic             r_all_correct;
    logic [3:0]       r_attempts;

    logic             w_full;
    logic [3:0]       w_cursor_m1;
    logic             w_match;

    assign w_full      = (r_cursor == c_SLOTS4);
    assign w_cursor_m1 = r_cursor - 4'd1;
    // Grading compares against the shadow copy so target_word may change
    // freely once the guess has been accepted.
    assign w_match     = (r_slot[r_idx] == r_shadow[r_idx]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= c_ST_EDIT;
            for (int i = 0; i < SLOTS; i++) begin
                r_slot[i]   <= BLANK_CODE;
                r_shadow[i] <= 5'd0;
            end
            r_flag        <= '0;
            r_cursor      <= 4'd0;
            r_idx         <= 3'd0;
            r_mode        <= 1'b0;
            r_busy        <= 1'b0;
            r_all_correct <= 1'b0;
            r_attempts    <= 4'd0;
        end else begin
            case (r_state)
                c_ST_EDIT: begin
                    // Priority: clear > submit > backspace > letter_valid.
                    if (clear) begin
                        for (int i = 0; i < SLOTS; i++) r_slot[i] <= BLANK_CODE;
                        r_cursor      <= 4'd0;
                        r_flag        <= '0;
                        r_all_correct <= 1'b0;
                    end else if (submit) begin
                        if (w_full) begin
                            for (int i = 0; i < SLOTS; i++)
                                r_shadow[i] <= target_word[5*i +: 5];
                            r_flag        <= '0;
                            r_all_correct <= 1'b0;
                            r_busy        <= 1'b1;
                            r_idx         <= 3'd0;
                            r_state       <= c_ST_CHECK;
                        end
                    end else if (backspace) begin
                        if (r_cursor != 4'd0) begin
                            r_slot[w_cursor_m1[2:0]] <= BLANK_CODE;
                            r_cursor                 <= w_cursor_m1;
                        end
                    end else if (letter_valid) begin
                        if ((letter_in <= CHAR_MAX) && !w_full) begin
                            r_slot[r_cursor[2:0]] <= letter_in;
                            r_cursor              <= r_cursor + 4'd1;
                        end
                    end
                end

                c_ST_CHECK: begin
                    if (clear) begin
                        for (int i = 0; i < SLOTS; i++) r_slot[i] <= BLANK_CODE;
                        r_cursor      <= 4'd0;
                        r_flag        <= '0;
                        r_all_correct <= 1'b0;
                        r_busy        <= 1'b0;
                        r_mode        <= 1'b0;
                        r_state       <= c_ST_EDIT;
                    end else begin
                        r_flag[r_idx] <= w_match;
                        r_idx         <= r_idx + 3'd1;
                        if (r_idx == c_LAST_IDX) begin
                            // The last flag is still being written this edge,
                            // so fold w_match in directly.
                            r_all_correct <= w_match & (&r_flag[SLOTS-2:0]);
                            r_busy        <= 1'b0;
                            r_mode        <= 1'b1;
                            if (r_attempts != 4'd15)
                                r_attempts <= r_attempts + 4'd1;
                            r_state       <= c_ST_SHOW;
                        end
                    end
                end

                c_ST_SHOW: begin
                    if (clear) begin
                        for (int i = 0; i < SLOTS; i++) r_slot[i] <= BLANK_CODE;
                        r_cursor      <= 4'd0;
                        r_flag        <= '0;
                        r_all_correct <= 1'b0;
                        r_mode        <= 1'b0;
                        r_state       <= c_ST_EDIT;
                    end
                end

                default: r_state <= c_ST_EDIT;
            endcase
        end
    end

    assign alphabet_0   = r_slot[0];
    assign alphabet_1   = r_slot[1];
    assign alphabet_2   = r_slot[2];
    assign alphabet_3   = r_slot[3];
    assign alphabet_4   = r_slot[4];
    assign alphabet_5   = r_slot[5];
    assign alphabet_6   = r_slot[6];
    assign alphabet_7   = r_slot[7];
    assign is_correct_0 = r_flag[0];
    assign is_correct_1 = r_flag[1];
    assign is_correct_2 = r_flag[2];
    assign is_correct_3 = r_flag[3];
    assign is_correct_4 = r_flag[4];
    assign is_correct_5 = r_flag[5];
    assign is_correct_6 = r_flag[6];
    assign is_correct_7 = r_flag[7];
    assign mode         = r_mode;
    assign cursor       = r_cursor;
    assign full         = w_full;
    assign busy         = r_busy;
    assign all_correct  = r_all_correct;
    assign attempts     = r_attempts;

endmodule
`default_nettype wire

// File: tb/tb_guess_entry_writer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_guess_entry_writer
//  Purpose  : Self-checking bench for guess_entry_writer. Expected grade
//             results are pushed to a scoreboard queue when a guess is
//             submitted and popped when the graded view appears.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_guess_entry_writer;

    logic        clk;
    logic        rst_n;
    logic [4:0]  letter_in;
    logic        letter_valid, backspace, submit, clear;
    logic [39:0] target_word;
    logic [4:0]  alphabet_0, alphabet_1, alphabet_2, alphabet_3;
    logic [4:0]  alphabet_4, alphabet_5, alphabet_6, alphabet_7;
    logic        is_correct_0, is_correct_1, is_correct_2, is_correct_3;
    logic        is_correct_4, is_correct_5, is_correct_6, is_correct_7;
    logic        mode, full, busy, all_correct;
    logic [3:0]  cursor, attempts;

    guess_entry_writer dut (
        .clk(clk), .rst_n(rst_n), .letter_in(letter_in), .letter_valid(letter_valid),
        .backspace(backspace), .submit(submit), .clear(clear), .target_word(target_word),
        .alphabet_0(alphabet_0), .alphabet_1(alphabet_1), .alphabet_2(alphabet_2),
        .alphabet_3(alphabet_3), .alphabet_4(alphabet_4), .alphabet_5(alphabet_5),
        .alphabet_6(alphabet_6), .alphabet_7(alphabet_7),
        .is_correct_0(is_correct_0), .is_correct_1(is_correct_1), .is_correct_2(is_correct_2),
        .is_correct_3(is_correct_3), .is_correct_4(is_correct_4), .is_correct_5(is_correct_5),
        .is_correct_6(is_correct_6), .is_correct_7(is_correct_7),
        .mode(mode), .cursor(cursor), .full(full), .busy(busy),
        .all_correct(all_correct), .attempts(attempts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wire [39:0] slots = {alphabet_7, alphabet_6, alphabet_5, alphabet_4,
                         alphabet_3, alphabet_2, alphabet_1, alphabet_0};
    wire [7:0]  flags = {is_correct_7, is_correct_6, is_correct_5, is_correct_4,
                         is_correct_3, is_correct_2, is_correct_1, is_correct_0};

    localparam logic [39:0] c_BLANK40 = {8{5'd27}};

    typedef struct packed {
        logic [7:0] flags;
        logic       allc;
        logic [3:0] att;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          checks = 0;
    int          errors = 0;
    int          n;
    logic [3:0]  exp_att = 4'd0;
    logic [39:0] word_bus;
    logic [39:0] tgt;

    function automatic logic [7:0] model_flags(input logic [39:0] s, input logic [39:0] t);
        logic [7:0] f;
        for (int i = 0; i < 8; i++) f[i] = (s[5*i +: 5] == t[5*i +: 5]);
        return f;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [4:0] l);
        letter_in = l; letter_valid = 1'b1; tick; letter_valid = 1'b0;
    endtask

    task automatic do_clear;
        clear = 1'b1; tick; clear = 1'b0;
    endtask

    task automatic fill_word;
        for (int i = 0; i < 8; i++) press(word_bus[5*i +: 5]);
    endtask

    // Push the expected result of grading the current slots against t.
    task automatic push_expect(input logic [39:0] t);
        exp_t x;
        x.flags = model_flags(word_bus, t);
        x.allc  = &x.flags;
        exp_att = (exp_att == 4'd15) ? 4'd15 : exp_att + 4'd1;
        x.att   = exp_att;
        sb.push_back(x);
    endtask

    task automatic wait_show(output int cyc);
        cyc = 0;
        while (mode !== 1'b1 && cyc < 20) begin tick; cyc++; end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; tick; tick;
        checks++; if (slots !== c_BLANK40) begin errors++; $display("FAIL reset_slots: got %h expected %h", slots, c_BLANK40); end
        checks++; if (flags !== 8'h00) begin errors++; $display("FAIL reset_flags: got %h expected 00", flags); end
        checks++; if ({mode, full, busy, all_correct} !== 4'b0000) begin errors++; $display("FAIL reset_ctrl: got %b expected 0000", {mode, full, busy, all_correct}); end
        checks++; if (cursor !== 4'd0 || attempts !== 4'd0) begin errors++; $display("FAIL reset_counts: got cursor %0d attempts %0d expected 0 0", cursor, attempts); end
        rst_n = 1'b1;
        exp_att = 4'd0;
    endtask

    task automatic test_entry;
        fill_word;
        checks++; if (slots !== word_bus) begin errors++; $display("FAIL entry_slots: got %h expected %h", slots, word_bus); end
        checks++; if (cursor !== 4'd8 || full !== 1'b1 || mode !== 1'b0) begin errors++; $display("FAIL entry_ctrl: got cursor %0d full %b mode %b expected 8 1 0", cursor, full, mode); end
        press(5'd3);
        checks++; if (slots !== word_bus || cursor !== 4'd8) begin errors++; $display("FAIL entry_overflow: got %h cursor %0d expected %h 8", slots, cursor, word_bus); end
    endtask

    task automatic test_grade_match;
        tgt = word_bus;
        target_word = tgt;
        push_expect(tgt);
        submit = 1'b1; tick; submit = 1'b0;
        target_word = ~tgt;   // must not disturb the latched copy
        checks++; if (busy !== 1'b1 || mode !== 1'b0 || flags !== 8'h00) begin errors++; $display("FAIL match_start: got busy %b mode %b flags %h expected 1 0 00", busy, mode, flags); end
        for (int i = 0; i < 8; i++) begin
            tick;
            checks++; if (flags !== (8'hFF >> (7 - i))) begin errors++; $display("FAIL match_flags_%0d: got %h expected %h", i, flags, 8'hFF >> (7 - i)); end
            checks++; if (busy !== (i < 7) || mode !== (i == 7)) begin errors++; $display("FAIL match_busy_%0d: got busy %b mode %b expected %b %b", i, busy, mode, i < 7, i == 7); end
        end
        e = sb.pop_front();
        checks++; if (flags !== e.flags || all_correct !== e.allc) begin errors++; $display("FAIL match_result: got %h %b expected %h %b", flags, all_correct, e.flags, e.allc); end
        checks++; if (attempts !== e.att) begin errors++; $display("FAIL match_attempts: got %0d expected %0d", attempts, e.att); end
    endtask

    task automatic test_grade_mismatch;
        do_clear;
        fill_word;
        tgt = word_bus;
        tgt[14:10] = 5'd0;
        tgt[29:25] = 5'd0;
        target_word = tgt;
        push_expect(tgt);
        submit = 1'b1; tick; submit = 1'b0;
        wait_show(n);
        checks++; if (n !== 8) begin errors++; $display("FAIL mismatch_latency: got %0d expected 8", n); end
        e = sb.pop_front();
        checks++; if (flags !== e.flags || all_correct !== e.allc || mode !== 1'b1) begin errors++; $display("FAIL mismatch_result: got %h %b mode %b expected %h %b 1", flags, all_correct, mode, e.flags, e.allc); end
        checks++; if (flags !== 8'hDB) begin errors++; $display("FAIL mismatch_pattern: got %h expected db", flags); end
        checks++; if (attempts !== e.att) begin errors++; $display("FAIL mismatch_attempts: got %0d expected %0d", attempts, e.att); end
        press(5'd1); backspace = 1'b1; tick; backspace = 1'b0;
        checks++; if (slots !== word_bus || flags !== 8'hDB || mode !== 1'b1) begin errors++; $display("FAIL show_hold: got %h %h expected %h db", slots, flags, word_bus); end
    endtask

    task automatic test_backspace;
        do_clear;
        checks++; if (mode !== 1'b0 || slots !== c_BLANK40 || flags !== 8'h00 || all_correct !== 1'b0 || attempts !== exp_att) begin errors++; $display("FAIL show_clear: got mode %b slots %h flags %h attempts %0d", mode, slots, flags, attempts); end
        press(5'd1); press(5'd2); press(5'd3);
        backspace = 1'b1; tick; tick; backspace = 1'b0;
        checks++; if (cursor !== 4'd1 || slots !== {{7{5'd27}}, 5'd1}) begin errors++; $display("FAIL bs_state: got cursor %0d slots %h expected 1 %h", cursor, slots, {{7{5'd27}}, 5'd1}); end
        submit = 1'b1; tick; submit = 1'b0;
        checks++; if (busy !== 1'b0 || mode !== 1'b0 || cursor !== 4'd1) begin errors++; $display("FAIL bs_submit_ignored: got busy %b mode %b cursor %0d", busy, mode, cursor); end
        press(5'd30);
        checks++; if (cursor !== 4'd1 || slots !== {{7{5'd27}}, 5'd1}) begin errors++; $display("FAIL bad_letter: got cursor %0d slots %h", cursor, slots); end
        backspace = 1'b1; tick; tick; backspace = 1'b0;
        checks++; if (cursor !== 4'd0 || slots !== c_BLANK40) begin errors++; $display("FAIL bs_at_zero: got cursor %0d slots %h expected 0 %h", cursor, slots, c_BLANK40); end
    endtask

    task automatic test_priority;
        fill_word;
        tgt = word_bus;
        target_word = tgt;
        push_expect(tgt);
        letter_in = 5'd3; letter_valid = 1'b1; submit = 1'b1; tick;
        letter_valid = 1'b0; submit = 1'b0;
        checks++; if (busy !== 1'b1 || slots !== word_bus || cursor !== 4'd8) begin errors++; $display("FAIL prio_submit: got busy %b slots %h cursor %0d", busy, slots, cursor); end
        wait_show(n);
        e = sb.pop_front();
        checks++; if (n !== 8 || flags !== e.flags || attempts !== e.att) begin errors++; $display("FAIL prio_grade: got n %0d flags %h att %0d expected 8 %h %0d", n, flags, attempts, e.flags, e.att); end
        do_clear;
        fill_word;
        clear = 1'b1; submit = 1'b1; tick; clear = 1'b0; submit = 1'b0;
        tick; tick;
        checks++; if (busy !== 1'b0 || mode !== 1'b0 || cursor !== 4'd0 || slots !== c_BLANK40) begin errors++; $display("FAIL prio_clear: got busy %b mode %b cursor %0d slots %h", busy, mode, cursor, slots); end
    endtask

    task automatic test_abort;
        fill_word;
        target_word = word_bus;
        submit = 1'b1; tick; submit = 1'b0;
        tick; tick; tick; tick;
        checks++; if (flags !== 8'h0F || busy !== 1'b1) begin errors++; $display("FAIL abort_progress: got flags %h busy %b expected 0f 1", flags, busy); end
        do_clear;
        checks++; if (mode !== 1'b0 || busy !== 1'b0 || flags !== 8'h00 || cursor !== 4'd0 || slots !== c_BLANK40) begin errors++; $display("FAIL abort_state: got mode %b busy %b flags %h cursor %0d slots %h", mode, busy, flags, cursor, slots); end
        for (int i = 0; i < 10; i++) tick;
        checks++; if (mode !== 1'b0 || attempts !== exp_att) begin errors++; $display("FAIL abort_attempts: got mode %b attempts %0d expected 0 %0d", mode, attempts, exp_att); end
    endtask

    task automatic test_reset_in_show;
        fill_word;
        push_expect(word_bus);
        submit = 1'b1; tick; submit = 1'b0;
        wait_show(n);
        e = sb.pop_front();
        checks++; if (attempts !== e.att || all_correct !== e.allc) begin errors++; $display("FAIL rshow_grade: got att %0d allc %b expected %0d %b", attempts, all_correct, e.att, e.allc); end
        rst_n = 1'b0; tick; rst_n = 1'b1;
        checks++; if (slots !== c_BLANK40 || flags !== 8'h00 || {mode, full, busy, all_correct} !== 4'b0000 || cursor !== 4'd0 || attempts !== 4'd0) begin errors++; $display("FAIL rshow_reset: got slots %h flags %h ctrl %b cursor %0d attempts %0d", slots, flags, {mode, full, busy, all_correct}, cursor, attempts); end
        exp_att = 4'd0;
    endtask

    task automatic test_saturate;
        for (int k = 0; k < 16; k++) begin
            fill_word;
            push_expect(word_bus);
            submit = 1'b1; tick; submit = 1'b0;
            wait_show(n);
            e = sb.pop_front();
            checks++; if (mode !== 1'b1 || attempts !== e.att) begin errors++; $display("FAIL sat_attempt_%0d: got mode %b attempts %0d expected 1 %0d", k, mode, attempts, e.att); end
            do_clear;
        end
        checks++; if (attempts !== 4'd15) begin errors++; $display("FAIL sat_final: got %0d expected 15", attempts); end
    endtask

    initial begin
        rst_n = 1'b0; letter_in = 5'd0; letter_valid = 1'b0; backspace = 1'b0;
        submit = 1'b0; clear = 1'b0; target_word = 40'd0;
        word_bus = {5'd17, 5'd14, 5'd22, 5'd14, 5'd11, 5'd11, 5'd4, 5'd7};
        test_reset;
        test_entry;
        test_grade_match;
        test_grade_mismatch;
        test_backspace;
        test_priority;
        test_abort;
        test_reset_in_show;
        test_saturate;
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
